// File: rtl/operand_loader_pkg.sv
// Shared constants, state encoding and sizing for the operand loader.
package operand_loader_pkg;

    localparam int DATAWIDTH     = 8;
    localparam int NUMREGS       = 5;
    localparam int SELECTIONDECO = 4;

    // Decoder code that selects no data register.
    localparam logic [SELECTIONDECO-1:0] IDLESEL = 4'd11;

    localparam logic [2:0] NUMREGS_CNT = 3'(NUMREGS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_KICK,
        ST_WAIT
    } state_e;

endpackage

// File: rtl/operand_loader.sv
// Loads a burst of NUMREGS operands into the register file via bus C, then kicks the sorter.
// Optional macro OPERAND_LOADER_CHECKSUM_EN adds a running XOR of the burst on sChecksum.
module operand_loader
    import operand_loader_pkg::*;
(
    input  logic                     clk,
    input  logic                     lowRst,
    input  logic [DATAWIDTH-1:0]     sDataIn,
    input  logic                     sValid,
    output logic                     sReady,
    output logic [DATAWIDTH-1:0]     sBusC,
    output logic [SELECTIONDECO-1:0] sSelDecoC,
    output logic                     sLoadActive,
    output logic                     sStart,
    input  logic                     sSortDone,
`ifdef OPERAND_LOADER_CHECKSUM_EN
    output logic [DATAWIDTH-1:0]     sChecksum,
`endif
    output state_e                   sDbgState,
    output logic [2:0]               sBurstIdx
);

    state_e                   state_q, state_d;
    logic [2:0]               idx_q, idx_d;
    logic                     ready_q, ready_d;
    logic                     start_q, start_d;
    logic [DATAWIDTH-1:0]     bus_q, bus_d;
    logic [SELECTIONDECO-1:0] sel_q, sel_d;
    logic                     active_q, active_d;
    logic                     accept;

    // A byte transfers on any rising edge where sValid and sReady are both high;
    // with sReady low the source keeps sValid and sDataIn stable until it transfers.
    assign accept = sValid & ready_q;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        start_d  = 1'b0;
        bus_d    = bus_q;
        sel_d    = IDLESEL;
        active_d = 1'b0;

        if (accept) begin
            bus_d    = sDataIn;
            sel_d    = SELECTIONDECO'(idx_q);
            active_d = 1'b1;
            idx_d    = idx_q + 3'd1;
        end

        case (state_q)
            ST_IDLE, ST_LOAD: begin
                if (accept) begin
                    state_d = (idx_d == NUMREGS_CNT) ? ST_KICK : ST_LOAD;
                end
            end
            // First KICK cycle carries the last write; the second carries the start pulse.
            ST_KICK: begin
                if (start_q) begin
                    state_d = ST_WAIT;
                end else begin
                    start_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (sSortDone) begin
                    state_d = ST_IDLE;
                    idx_d   = 3'd0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
    end

    always_ff @(posedge clk or negedge lowRst) begin
        if (!lowRst) begin
            state_q  <= ST_IDLE;
            idx_q    <= 3'd0;
            ready_q  <= 1'b1;
            start_q  <= 1'b0;
            bus_q    <= '0;
            sel_q    <= IDLESEL;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            ready_q  <= ready_d;
            start_q  <= start_d;
            bus_q    <= bus_d;
            sel_q    <= sel_d;
            active_q <= active_d;
        end
    end

`ifdef OPERAND_LOADER_CHECKSUM_EN
    logic [DATAWIDTH-1:0] csum_q, csum_d;

    // The first accept of a burst restarts the running XOR.
    always_comb begin
        csum_d = csum_q;
        if (accept) begin
            csum_d = (state_q == ST_IDLE) ? sDataIn : (csum_q ^ sDataIn);
        end
    end

    always_ff @(posedge clk or negedge lowRst) begin
        if (!lowRst) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign sChecksum = csum_q;
`endif

    assign sReady      = ready_q;
    assign sBusC       = bus_q;
    assign sSelDecoC   = sel_q;
    assign sLoadActive = active_q;
    assign sStart      = start_q;
    assign sBurstIdx   = idx_q;
    assign sDbgState   = state_q;

endmodule

// File: tb/tb_operand_loader.sv
// Randomized and directed bench for operand_loader against a burst-level reference model.
module tb_operand_loader;
  import operand_loader_pkg::*;

  logic       clk;
  logic       lowRst;
  logic [7:0] sDataIn;
  logic       sValid;
  logic       sReady;
  logic [7:0] sBusC;
  logic [3:0] sSelDecoC;
  logic       sLoadActive;
  logic       sStart;
  logic       sSortDone;
  logic [2:0] sBurstIdx;
  state_e     sDbgState;
`ifdef OPERAND_LOADER_CHECKSUM_EN
  logic [7:0] sChecksum;
`endif

  operand_loader dut (
    .clk        (clk),
    .lowRst     (lowRst),
    .sDataIn    (sDataIn),
    .sValid     (sValid),
    .sReady     (sReady),
    .sBusC      (sBusC),
    .sSelDecoC  (sSelDecoC),
    .sLoadActive(sLoadActive),
    .sStart     (sStart),
    .sSortDone  (sSortDone),
`ifdef OPERAND_LOADER_CHECKSUM_EN
    .sChecksum  (sChecksum),
`endif
    .sDbgState  (sDbgState),
    .sBurstIdx  (sBurstIdx)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- counters ----------------
  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- stimulus controls ----------------
  logic [7:0] src_q[$];      // bytes the source still has to deliver, front is presented
  int valid_mode = 0;        // 0: always valid, 1: every other cycle, 2: random
  int valid_pct  = 60;
  int done_pct   = 0;
  int done_reqs  = 0;
  int done_served = 0;

  // ---------------- reference model ----------------
  int         m_cnt       = 0;     // operands accepted in the current burst
  bit         m_waiting   = 0;     // burst complete, sort not yet reported done
  int         m_cyc       = 0;     // posedge counter
  int         m_last_full = -100;  // edge of the burst-completing accept
  bit         m_last_accept = 0;
  logic       m_ready  = 1'b1;
  logic       m_start  = 1'b0;
  logic       m_active = 1'b0;
  logic [3:0] m_sel    = 4'd11;
  logic [7:0] m_bus    = 8'h00;
  logic [7:0] m_csum   = 8'h00;
  logic [11:0] exp_q[$];           // {index, data} writes still owed by the DUT

  always @(posedge clk or negedge lowRst) begin
    if (!lowRst) begin
      m_cnt = 0; m_waiting = 0; m_last_full = -100; m_last_accept = 0;
      m_ready = 1'b1; m_start = 1'b0; m_active = 1'b0;
      m_sel = 4'd11; m_bus = 8'h00; m_csum = 8'h00;
      exp_q.delete();
    end else begin
      bit acc;
      m_cyc++;
      acc = sValid && m_ready;
      m_last_accept = acc;
      m_start = (m_cyc == m_last_full + 1);
      if (m_waiting && sSortDone && m_cyc >= m_last_full + 3) begin
        m_waiting = 0;
        m_cnt = 0;
      end
      if (acc) begin
        m_sel = 4'(m_cnt);
        m_bus = sDataIn;
        m_active = 1'b1;
        m_csum = (m_cnt == 0) ? sDataIn : (m_csum ^ sDataIn);
        exp_q.push_back({4'(m_cnt), sDataIn});
        void'(src_q.pop_front());
        m_cnt++;
        if (m_cnt == NUMREGS) begin
          m_waiting = 1;
          m_last_full = m_cyc;
        end
      end else begin
        m_sel = 4'd11;
        m_active = 1'b0;
      end
      m_ready = !m_waiting;
    end
  end

  // ---------------- driver ----------------
  initial begin
    bit alt;
    bit want;
    alt = 0;
    sValid = 1'b0;
    sDataIn = 8'h00;
    sSortDone = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      want = 0;
      if (sValid && !m_last_accept) begin
        want = 1;
      end else begin
        case (valid_mode)
          0: want = 1;
          1: begin alt = !alt; want = alt; end
          default: want = ($urandom_range(99) < valid_pct);
        endcase
      end
      sValid  = (src_q.size() > 0) && want;
      sDataIn = (src_q.size() > 0) ? src_q[0] : 8'($urandom);
      if (done_reqs != done_served) begin
        sSortDone = 1'b1;
        done_served++;
      end else begin
        sSortDone = ($urandom_range(99) < done_pct);
      end
    end
  end

  // ---------------- per-cycle compare + scoreboard ----------------
  logic [11:0] dut_wr_q[$];
  int n_dut_start = 0;

  always @(negedge clk) begin
    check("ready",  32'(sReady),      32'(m_ready));
    check("sel",    32'(sSelDecoC),   32'(m_sel));
    check("bus",    32'(sBusC),       32'(m_bus));
    check("active", 32'(sLoadActive), 32'(m_active));
    check("start",  32'(sStart),      32'(m_start));
    check("idx",    32'(sBurstIdx),   32'(m_cnt));
`ifdef OPERAND_LOADER_CHECKSUM_EN
    check("csum",   32'(sChecksum),   32'(m_csum));
`endif
    if (sStart === 1'b1) n_dut_start++;
    if (sLoadActive === 1'b1) begin
      dut_wr_q.push_back({sSelDecoC, sBusC});
      if (exp_q.size() == 0) check("write_unexpected", 32'({sSelDecoC, sBusC}), 32'hFFF);
      else check("write", 32'({sSelDecoC, sBusC}), 32'(exp_q.pop_front()));
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_waiting(input string name, input int budget);
    int n = 0;
    while (!(m_waiting && m_cyc >= m_last_full + 3) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_reached_wait"}, 32'(m_waiting && m_cyc >= m_last_full + 3), 32'd1);
  endtask

  task automatic sort_done();
    @(negedge clk);
    done_reqs++;
    repeat (3) @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  logic [7:0] b1[5];
  logic [7:0] b4[5];
  int start_before;

  initial begin
    b1[0] = 8'h09; b1[1] = 8'h02; b1[2] = 8'h07; b1[3] = 8'h01; b1[4] = 8'h05;
    b4[0] = 8'h01; b4[1] = 8'h02; b4[2] = 8'h04; b4[3] = 8'h08; b4[4] = 8'h10;
    lowRst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready",  32'(sReady),      32'd1);
    check("rst_sel",    32'(sSelDecoC),   32'd11);
    check("rst_bus",    32'(sBusC),       32'd0);
    check("rst_start",  32'(sStart),      32'd0);
    check("rst_active", 32'(sLoadActive), 32'd0);
    check("rst_idx",    32'(sBurstIdx),   32'd0);
    #3 lowRst = 1'b1;

    // back-to-back burst
    valid_mode = 0;
    dut_wr_q.delete();
    n_dut_start = 0;
    for (int i = 0; i < 5; i++) src_q.push_back(b1[i]);
    wait_waiting("b2b", 40);
    check("b2b_nwrites", 32'(dut_wr_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < dut_wr_q.size(); i++)
      check("b2b_wr", 32'(dut_wr_q[i]), 32'({4'(i), b1[i]}));
    check("b2b_starts", 32'(n_dut_start), 32'd1);
    sort_done();

    // gapped valid
    valid_mode = 1;
    dut_wr_q.delete();
    n_dut_start = 0;
    for (int i = 0; i < 5; i++) src_q.push_back(8'($urandom));
    wait_waiting("gap", 60);
    check("gap_nwrites", 32'(dut_wr_q.size()), 32'd5);
    check("gap_starts", 32'(n_dut_start), 32'd1);
    sort_done();

    // backpressure in WAIT
    valid_mode = 0;
    for (int i = 0; i < 5; i++) src_q.push_back(8'($urandom));
    src_q.push_back(8'h33);
    dut_wr_q.delete();
    wait_waiting("bp", 40);
    repeat (4) @(negedge clk);
    check("bp_held_nwrites", 32'(dut_wr_q.size()), 32'd5);
    check("bp_ready_low", 32'(sReady), 32'd0);
    dut_wr_q.delete();
    sort_done();
    check("bp_nwrites", 32'(dut_wr_q.size()), 32'd1);
    if (dut_wr_q.size() > 0) check("bp_wr33", 32'(dut_wr_q[0]), 32'h033);
    for (int i = 0; i < 4; i++) src_q.push_back(8'($urandom));
    wait_waiting("bp_fill", 40);
    sort_done();

    // reset after three accepts
    for (int i = 0; i < 3; i++) src_q.push_back(8'($urandom));
    for (int n = 0; n < 40 && m_cnt != 3; n++) @(negedge clk);
    check("mid_three", 32'(m_cnt), 32'd3);
    start_before = n_dut_start;
    #3 lowRst = 1'b0;
    #1;
    check("mid_rst_sel",    32'(sSelDecoC),   32'd11);
    check("mid_rst_bus",    32'(sBusC),       32'd0);
    check("mid_rst_active", 32'(sLoadActive), 32'd0);
    check("mid_rst_idx",    32'(sBurstIdx),   32'd0);
    check("mid_rst_ready",  32'(sReady),      32'd1);
    repeat (2) @(negedge clk);
    #3 lowRst = 1'b1;
    repeat (5) @(negedge clk);
    check("mid_no_start", 32'(n_dut_start - start_before), 32'd0);

    // new burst after reset, checksum pattern
    dut_wr_q.delete();
    for (int i = 0; i < 5; i++) src_q.push_back(b4[i]);
    wait_waiting("post_rst", 40);
    check("post_rst_nwrites", 32'(dut_wr_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < dut_wr_q.size(); i++)
      check("post_rst_wr", 32'(dut_wr_q[i]), 32'({4'(i), b4[i]}));
    check("model_csum_pin", 32'(m_csum), 32'h1F);
`ifdef OPERAND_LOADER_CHECKSUM_EN
    check("csum_1f", 32'(sChecksum), 32'h1F);
`endif
    sort_done();

    // randomized traffic, sort-done noise in every state
    valid_mode = 2;
    valid_pct  = 60;
    done_pct   = 20;
    for (int i = 0; i < 200; i++) src_q.push_back(8'($urandom));
    for (int n = 0; n < 4000 && src_q.size() != 0; n++) @(negedge clk);
    check("rand_drained", 32'(src_q.size()), 32'd0);
    done_pct = 0;
    repeat (10) @(negedge clk);
    sort_done();
    repeat (5) @(negedge clk);
    check("final_exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("final_ready", 32'(sReady), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
